// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default widths, state encodings and
// the helpers that split a byte address into index and tag.
package icache_pkg;

  localparam int RAM_ADDRESS_WIDTH = 17;
  localparam int DATA_WIDTH        = 32;
  localparam int ICACHE_INDEX_BITS = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    ICACHE_IDLE      = 1'b0,
    ICACHE_MISS_WAIT = 1'b1
  } icache_state_t;

  // Word-aligned lines: two byte-offset bits sit below the index.
  function automatic int icache_tag_bits(input int addr_w, input int index_bits);
    return addr_w - 2 - index_bits;
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Direct-mapped line storage: valid bits (async reset), tag and data arrays (not reset).
// Combinational read port, one synchronous write port; a write always sets the line valid.
module icache_line_ram
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = 7,
  parameter int DATA_W     = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  // Tag and data carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache; hit 1 cycle, miss = memCtrl latency + 2.
// rdy=0 freezes everything, misbranch flushes a pending miss; ICACHE_PERF_EN adds hit/miss counters.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDRESS_WIDTH,
  parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  in_misbranch,
  input  logic                  in_fetch_req,
  input  logic [ADDR_WIDTH-1:0] in_fetch_pc,
  output logic                  out_fetch_valid,
  output logic [DATA_WIDTH-1:0] out_fetch_instr,
  output logic                  out_mem_get_instr,
  output logic [ADDR_WIDTH-1:0] out_mem_address,
  input  logic                  in_mem_instr_valid,
  input  logic [DATA_WIDTH-1:0] in_mem_instr
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           out_hit_cnt,
  output logic [31:0]           out_miss_cnt
`endif
);

  localparam int TAG_BITS = icache_tag_bits(ADDR_WIDTH, INDEX_BITS);

  icache_state_t         state, state_nxt;
  logic                  fetch_valid_nxt;
  logic [DATA_WIDTH-1:0] fetch_instr_nxt;
  logic                  get_instr_nxt;
  logic [ADDR_WIDTH-1:0] mem_address_nxt;
  logic                  fill_en;

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0]   pc_tag, fill_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  accept, hit;

  assign rd_idx   = in_fetch_pc[INDEX_BITS+1:2];
  assign pc_tag   = in_fetch_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  // The fill targets the held miss address, not whatever pc the fetcher shows now.
  assign wr_idx   = out_mem_address[INDEX_BITS+1:2];
  assign fill_tag = out_mem_address[ADDR_WIDTH-1:INDEX_BITS+2];

  assign accept = (state == ICACHE_IDLE) && in_fetch_req && !out_fetch_valid && !in_misbranch;
  assign hit    = rd_valid && (rd_tag == pc_tag);

  icache_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_W     (DATA_WIDTH)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en && rdy),
    .wr_idx   (wr_idx),
    .wr_tag   (fill_tag),
    .wr_data  (in_mem_instr)
  );

  always_comb begin
    state_nxt       = state;
    fetch_valid_nxt = FALSE;
    fetch_instr_nxt = out_fetch_instr;
    get_instr_nxt   = FALSE;
    mem_address_nxt = out_mem_address;
    fill_en         = FALSE;
    if (in_misbranch) begin
      state_nxt = ICACHE_IDLE;
    end else begin
      case (state)
        ICACHE_IDLE: begin
          if (accept) begin
            if (hit) begin
              fetch_valid_nxt = TRUE;
              fetch_instr_nxt = rd_data;
            end else begin
              get_instr_nxt   = TRUE;
              mem_address_nxt = in_fetch_pc;
              state_nxt       = ICACHE_MISS_WAIT;
            end
          end
        end
        ICACHE_MISS_WAIT: begin
          if (in_mem_instr_valid) begin
            fill_en         = TRUE;
            fetch_valid_nxt = TRUE;
            fetch_instr_nxt = in_mem_instr;
            state_nxt       = ICACHE_IDLE;
          end
        end
        default: state_nxt = ICACHE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ICACHE_IDLE;
      out_fetch_valid   <= FALSE;
      out_fetch_instr   <= '0;
      out_mem_get_instr <= FALSE;
      out_mem_address   <= '0;
    end else if (rdy) begin
      state             <= state_nxt;
      out_fetch_valid   <= fetch_valid_nxt;
      out_fetch_instr   <= fetch_instr_nxt;
      out_mem_get_instr <= get_instr_nxt;
      out_mem_address   <= mem_address_nxt;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hit_cnt  <= '0;
      out_miss_cnt <= '0;
    end else if (rdy && accept) begin
      if (hit) out_hit_cnt  <= out_hit_cnt + 32'd1;
      else     out_miss_cnt <= out_miss_cnt + 32'd1;
    end
  end
`endif

endmodule
